// File: rtl/steak_drawer_pkg.sv
// steak_drawer_pkg: shared colour/screen constants, FSM state type and sizing helper
package steak_drawer_pkg;
  localparam int COL_W = 9;
  localparam int SCR_W = 160;
  localparam int SCR_H = 120;
  localparam int X_W = 8;
  localparam int Y_W = 7;
  typedef logic [COL_W-1:0] colour_t;
  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;
  // Doneness colours shared with the steak controller (RGB 3:3:3)
  localparam colour_t COL_NONE        = 9'h000;
  localparam colour_t COL_FAT         = 9'h1FF;
  localparam colour_t COL_RAW         = 9'h1C0;
  localparam colour_t COL_MEDIUM_RARE = 9'h180;
  localparam colour_t COL_MEDIUM      = 9'h1A4;
  localparam colour_t COL_WELL_DONE   = 9'h124;
  localparam colour_t COL_BURNT       = 9'h049;
  function automatic int cnt_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/steak_drawer_raster_counter.sv
// raster_counter: row-major cx/cy sweep counters over a W x H rectangle
//   clr  - synchronous clear of both counters (wins over en)
//   en   - advance one pixel; cx wraps at W-1 and carries into cy
//   cx/cy - current column/row offset, last - at (W-1, H-1)
module raster_counter
  import steak_drawer_pkg::*;
#(
  parameter int W = 16,
  parameter int H = 12
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                clr,
  input  logic                en,
  output logic [cnt_w(W)-1:0] cx,
  output logic [cnt_w(H)-1:0] cy,
  output logic                last
);
  logic end_x, end_y;
  assign end_x = cx == cnt_w(W)'(W - 1);
  assign end_y = cy == cnt_w(H)'(H - 1);
  assign last = end_x && end_y;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      cx <= '0;
      cy <= '0;
    end else if (clr) begin
      cx <= '0;
      cy <= '0;
    end else if (en) begin
      cx <= end_x ? '0 : cx + 1'b1;
      if (end_x) cy <= end_y ? '0 : cy + 1'b1;
    end
endmodule

// File: rtl/steak_drawer.sv
// steak_drawer: redraws a fat-bordered steak rectangle on every colour change or redraw request
//   colour_muscle/colour_fat - interior/border colours, sampled when a sweep starts
//   redraw                   - request one more sweep with unchanged colours
//   x/y/colour/plot          - VGA adapter pixel-write port, one pixel per cycle
//   busy                     - sweep in progress, done - pulse after the last pixel
module steak_drawer
  import steak_drawer_pkg::*;
#(
  parameter int X0 = 40,
  parameter int Y0 = 30,
  parameter int W  = 16,
  parameter int H  = 12,
  parameter int B  = 2
) (
  input  logic           clk,
  input  logic           resetn,
  input  colour_t        colour_muscle,
  input  colour_t        colour_fat,
  input  logic           redraw,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output colour_t        colour,
  output logic           plot,
  output logic           busy,
  output logic           done
);
  if (X0 + W > SCR_W || Y0 + H > SCR_H || 2 * B >= W || 2 * B >= H) begin : g_bad_geometry
    $error("steak_drawer: sprite geometry out of range");
  end
  state_t state;
  colour_t snap_muscle, snap_fat;
  logic pending, start, last, border;
  logic [cnt_w(W)-1:0] cx;
  logic [cnt_w(H)-1:0] cy;
  raster_counter #(.W(W), .H(H)) u_raster (
    .clk   (clk),
    .resetn(resetn),
    .clr   (start),
    .en    (state == DRAW),
    .cx    (cx),
    .cy    (cy),
    .last  (last)
  );
  assign start = state == IDLE && (pending || colour_muscle != snap_muscle || colour_fat != snap_fat);
  assign border = 32'(cx) < B || 32'(cx) >= W - B || 32'(cy) < B || 32'(cy) >= H - B;
  // Reset forces a first sweep; a redraw landing on the start edge queues another
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      snap_muscle <= '0;
      snap_fat <= '0;
      pending <= 1'b1;
    end else begin
      pending <= redraw | (pending & ~start);
      if (start) begin
        snap_muscle <= colour_muscle;
        snap_fat <= colour_fat;
      end
      state <= start ? DRAW : state == DRAW ? (last ? DONE : DRAW) : IDLE;
    end
  // Outputs decode only registered state, so asynchronous reset clears them at once
  assign busy = state == DRAW;
  assign plot = busy;
  assign done = state == DONE;
  assign x = busy ? X_W'(X0 + 32'(cx)) : '0;
  assign y = busy ? Y_W'(Y0 + 32'(cy)) : '0;
  assign colour = busy ? (border ? snap_fat : snap_muscle) : '0;
endmodule

// File: tb/tb_steak_drawer.sv
// tb_steak_drawer: scoreboard bench for steak_drawer with directed sweeps
module tb_steak_drawer;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [8:0] colour_muscle = 9'h0, colour_fat = 9'h0;
  logic redraw = 1'b0;
  logic [7:0] x;
  logic [6:0] y;
  logic [8:0] colour;
  logic plot, busy, done;
  steak_drawer dut (
    .clk(clk), .resetn(resetn), .colour_muscle(colour_muscle), .colour_fat(colour_fat),
    .redraw(redraw), .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  int compared = 0, mismatched = 0;
  logic [23:0] q[$];
  logic [8:0] seen [0:159][0:119];
  int cyc = 0, last_plot_cyc = 0, gap = 0, run_len = 0, sweep_px = 0, done_cnt = 0;
  logic prev_plot = 1'b0;
  logic [7:0] last_x, first_x;
  logic [6:0] last_y, first_y;
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask
  task automatic push_sweep(logic [8:0] m, logic [8:0] f);
    for (int cy = 0; cy < 12; cy++)
      for (int cx = 0; cx < 16; cx++)
        q.push_back({8'(40 + cx), 7'(30 + cy), (cx < 2 || cx >= 14 || cy < 2 || cy >= 10) ? f : m});
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_redraw();
    redraw = 1'b1;
    tick();
    redraw = 1'b0;
  endtask
  task automatic wait_dones(int n);
    int target = done_cnt + n;
    int t = 0;
    while (done_cnt < target && t < 3000) begin
      tick();
      t++;
    end
    check("sweep completes", 32'(done_cnt >= target), 1);
    check("queue drained", q.size(), 0);
  endtask
  task automatic wait_px(int n);
    int t = 0;
    while (!(busy && sweep_px == n) && t < 3000) begin
      tick();
      t++;
    end
    check("reached pixel", sweep_px, n);
  endtask
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (plot) begin
      if (!prev_plot) begin
        gap = cyc - last_plot_cyc;
        run_len = 0;
        sweep_px = 0;
        first_x = x;
        first_y = y;
      end
      if (q.size() == 0) check("unexpected plot", {x, y, colour}, 0);
      else check("pixel", {x, y, colour}, q.pop_front());
      check("busy with plot", busy, 1);
      if (x < 160 && y < 120) seen[x][y] = colour;
      run_len++;
      sweep_px++;
      last_x = x;
      last_y = y;
      last_plot_cyc = cyc;
    end
    if (done) begin
      check("done follows last plot", prev_plot, 1);
      check("sweep length", run_len, 192);
      check("last pixel", {last_x, last_y}, {8'd55, 7'd41});
      done_cnt++;
    end
    prev_plot = plot;
  end
  initial begin
    int np, nb, nd;
    repeat (3) tick();
    check("reset outputs", {x, y, colour, plot, busy, done}, 0);
    push_sweep(9'h000, 9'h000);
    resetn = 1'b1;
    wait_dones(1);
    check("first pixel", {first_x, first_y}, {8'd40, 7'd30});
    colour_fat = 9'h1C0;
    colour_muscle = 9'h038;
    push_sweep(9'h038, 9'h1C0);
    wait_dones(1);
    check("interior 42,32", seen[42][32], 9'h038);
    check("border 41,32", seen[41][32], 9'h1C0);
    check("interior 53,39", seen[53][39], 9'h038);
    check("border 54,39", seen[54][39], 9'h1C0);
    check("border 53,40", seen[53][40], 9'h1C0);
    push_sweep(9'h038, 9'h1C0);
    pulse_redraw();
    wait_px(20);
    push_sweep(9'h038, 9'h1C0);
    pulse_redraw();
    wait_dones(2);
    push_sweep(9'h038, 9'h1C0);
    pulse_redraw();
    wait_px(50);
    colour_muscle = 9'h007;
    push_sweep(9'h007, 9'h1C0);
    wait_dones(2);
    check("restart gap", gap, 3);
    check("second sweep interior", seen[42][32], 9'h007);
    np = 0;
    nb = 0;
    nd = 0;
    repeat (1000) begin
      tick();
      np += int'(plot);
      nb += int'(busy);
      nd += int'(done);
    end
    check("steady plot", np, 0);
    check("steady busy", nb, 0);
    check("steady done", nd, 0);
    colour_muscle = 9'h038;
    push_sweep(9'h038, 9'h1C0);
    wait_px(100);
    resetn = 1'b0;
    #1;
    check("async reset plot", plot, 0);
    check("async reset busy", busy, 0);
    q.delete();
    colour_muscle = 9'h000;
    colour_fat = 9'h000;
    repeat (2) tick();
    push_sweep(9'h000, 9'h000);
    resetn = 1'b1;
    wait_dones(1);
    check("post-reset colour", seen[47][35], 9'h000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
